// File: rtl/exhaustive_vector_sweeper.sv
// Drives every N_IN-bit input vector onto a combinational block in ascending order,
// samples its output after a settle interval and checks the truth table against EXPECTED.
module exhaustive_vector_sweeper #(
  parameter int unsigned              N_IN     = 3,
  parameter int unsigned              SETTLE   = 2,
  parameter logic [(2**N_IN)-1:0]     EXPECTED = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        dut_o,
  output logic [N_IN-1:0]             vec_out,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [(2**N_IN)-1:0]        result,
  output logic [N_IN:0]               mismatch_cnt,
  output logic [N_IN-1:0]             first_fail,
  output logic                        first_fail_valid
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CNT_W_SETTLE_LAST = SETTLE - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;

  logic             sample_c;
  logic             mism_c;
  logic             last_vec_c;
  logic [N_IN:0]    mismatch_next_c;

  // Sample strobe and the comparison for the vector currently held on vec_out.
  always_comb begin
    sample_c        = 1'b0;
    mism_c          = 1'b0;
    last_vec_c      = 1'b0;
    mismatch_next_c = mismatch_cnt;
    if (state == APPLY && settle_cnt == CNT_W'(CNT_W_SETTLE_LAST)) begin
      sample_c = 1'b1;
    end
    mism_c          = sample_c && (dut_o != EXPECTED[vec_out]);
    last_vec_c      = (vec_out == {N_IN{1'b1}});
    mismatch_next_c = mismatch_cnt + (N_IN + 1)'(mism_c);
  end

  // Sweep controller; start is honoured only when no sweep is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      result           <= '0;
      mismatch_cnt     <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= APPLY;
            settle_cnt       <= '0;
            vec_out          <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            result           <= '0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        APPLY: begin
          if (!sample_c) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end else begin
            result[vec_out] <= dut_o;
            mismatch_cnt    <= mismatch_next_c;
            if (mism_c && !first_fail_valid) begin
              first_fail       <= vec_out;
              first_fail_valid <= 1'b1;
            end
            if (!last_vec_c) begin
              vec_out    <= vec_out + N_IN'(1);
              settle_cnt <= '0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mismatch_next_c == '0);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exhaustive_vector_sweeper.md
Name: exhaustive_vector_sweeper

Overview:
- Upstream stimulus-and-capture stage for our small 3-input combinational expression blocks.
- Drives every input combination onto the block under test in ascending binary order, waits a settle interval, and samples the block's single output.
- Builds the observed truth table and compares it against an expected truth table.
- Reports pass/fail, the mismatch count and the first failing vector, so gate-level expression blocks can be self-checked in hardware instead of only by a bench.

Parameters:
- N_IN, 3, number of DUT inputs driven; the sweep covers 2**N_IN vectors.
- SETTLE, 2, cycles each vector is held before sampling; legal range is at least 1.
- EXPECTED, {2**N_IN{1'b0}}, expected truth table; bit k is the required output for input vector k.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- dut_o  input  1  output of the block under test.
- vec_out  output  N_IN  input vector to the DUT; MSB→first DUT input (a), LSB→last (c).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start.
- pass  output  1  valid while done is high; 1 iff result equals EXPECTED.
- result  output  2**N_IN  captured truth table; bit k = dut_o sampled for vector k.
- mismatch_cnt  output  N_IN+1  number of vectors where the sample differs from EXPECTED.
- first_fail  output  N_IN  lowest-index mismatching vector.
- first_fail_valid  output  1  high once any mismatch has been recorded in this sweep.

Behaviour:
- Reset (asynchronous, immediate, including mid-sweep):
  - state=IDLE.
  - vec_out, result, mismatch_cnt, first_fail = 0.
  - busy, done, pass, first_fail_valid = 0.
  - settle counter = 0.
- States: IDLE, APPLY, DONE.
- IDLE, start=1:
  - Next edge: state=APPLY, vec_out=0, settle counter=0, busy=1.
  - Clears result, mismatch_cnt, first_fail, first_fail_valid.
- APPLY:
  - vec_out is held constant for exactly SETTLE cycles.
  - The settle counter increments each cycle while below SETTLE-1.
  - On the edge where counter==SETTLE-1, dut_o is captured into result[vec_out] and compared with EXPECTED[vec_out].
  - On mismatch: mismatch_cnt increments; if first_fail_valid=0, first_fail=vec_out and first_fail_valid=1.
  - On that same edge, if vec_out < 2**N_IN-1: vec_out increments and counter=0.
  - Otherwise: state=DONE, busy=0, done=1, pass=(mismatch_cnt after update == 0).
- Latency: start accepted at edge T0; done rises at edge T0 + 2**N_IN*SETTLE. Default is 16 cycles.
- DONE:
  - All outputs hold; vec_out holds the last vector (all ones).
  - start=1 restarts exactly as from IDLE, with the same clears on the same edge.
- start while busy=1 is ignored and has no effect on the sweep.
- pass is 0 whenever done=0.
- mismatch_cnt width N_IN+1 holds the maximum 2**N_IN without wrap.
- vec_out increment never wraps within a sweep; the terminal vector triggers DONE.
- dut_o is sampled synchronously; settle covers DUT combinational delay only, with no synchronizer.

Test Plan:
- Reset/idle: assert rst for 3 cycles, then start=0 for 10 cycles -> all outputs 0, state stays IDLE.
- Matching DUT: EXPECTED=8'h00, dut_o tied 0, pulse start -> vec_out steps 0..7, each held 2 cycles; done at start+16 cycles; result=8'h00, pass=1, mismatch_cnt=0, first_fail_valid=0.
- Single mismatch: EXPECTED=8'h00, dut_o=1 only when vec_out==3'b101 -> result=8'h20, pass=0, mismatch_cnt=1, first_fail=5, first_fail_valid=1.
- Multiple mismatch: dut_o tied 1, EXPECTED=8'h0F -> result=8'hFF, mismatch_cnt=4, first_fail=4, pass=0.
- Restart and ignore: start pulses while busy leave timing unchanged. Start in DONE -> result/mismatch cleared on the accept edge; second sweep with a correct DUT gives pass=1.
- Mid-sweep reset with SETTLE=1: assert rst while vec_out=3 -> outputs clear immediately without a clock edge. A new start after release yields a full 8-vector sweep from vector 0.
